// File: rtl/mod_m_updown_counter.sv
// Runtime-programmable modulo-M up/down counter with wrap/one-shot modes, load and terminal ticks.
// Optional modulo-P prescaler on the count enable when MOD_COUNTER_PRESCALE_EN is defined.
module mod_m_updown_counter #(
  parameter int unsigned N         = 8,
  parameter int unsigned M_DEFAULT = 10
`ifdef MOD_COUNTER_PRESCALE_EN
  ,
  parameter int unsigned P         = 4
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         oneshot,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         m_wr,
  input  logic [N-1:0] m_in,
  output logic [N-1:0] q,
  output logic [N-1:0] m_cur,
  output logic         max_tick,
  output logic         min_tick,
  output logic         done
);

  logic [N-1:0] m_pend;
  logic         pend_v;
  logic [N-1:0] q_nxt, m_cur_nxt, m_pend_nxt, m_eff;
  logic         pend_v_nxt, done_nxt;
  logic         step, term_up, term_dn;

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
  logic [PW-1:0] pre, pre_nxt;
  logic          pre_last;

  assign pre_last = (pre == PW'(P - 1));

  // Prescaler restarts on load so the first post-load step is a full P cycles away.
  always_comb begin
    pre_nxt = pre;
    if (load)
      pre_nxt = '0;
    else if (en)
      pre_nxt = pre_last ? '0 : pre + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pre <= '0;
    else     pre <= pre_nxt;
  end
`else
  logic pre_last;
  assign pre_last = 1'b1;
`endif

  // Modulus in effect after this edge if a wrap or load applies the pending value.
  assign m_eff   = pend_v ? m_pend : m_cur;
  assign term_up = (q == m_cur - N'(1));
  assign term_dn = (q == '0);
  assign step    = en & ~done & ~load & pre_last;

  assign max_tick = step & up & term_up;
  assign min_tick = step & ~up & term_dn;

  always_comb begin
    q_nxt      = q;
    m_cur_nxt  = m_cur;
    m_pend_nxt = m_pend;
    pend_v_nxt = pend_v;
    done_nxt   = done;

    if (load) begin
      m_cur_nxt  = m_eff;
      pend_v_nxt = 1'b0;
      done_nxt   = 1'b0;
      q_nxt      = (load_val > m_eff - N'(1)) ? m_eff - N'(1) : load_val;
    end else if (step) begin
      if (up ? term_up : term_dn) begin
        if (oneshot) begin
          done_nxt = 1'b1;
        end else begin
          m_cur_nxt  = m_eff;
          pend_v_nxt = 1'b0;
          q_nxt      = up ? '0 : m_eff - N'(1);
        end
      end else begin
        q_nxt = up ? q + N'(1) : q - N'(1);
      end
    end

    // A fresh write lands after any apply above, so it stays pending for the next event.
    if (m_wr && (m_in >= N'(2))) begin
      m_pend_nxt = m_in;
      pend_v_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      m_cur  <= N'(M_DEFAULT);
      m_pend <= '0;
      pend_v <= 1'b0;
      done   <= 1'b0;
    end else begin
      q      <= q_nxt;
      m_cur  <= m_cur_nxt;
      m_pend <= m_pend_nxt;
      pend_v <= pend_v_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mod_m_updown_counter.sv
// Directed bench for mod_m_updown_counter in its default (no prescaler) build.
module tb_mod_m_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, oneshot, load, m_wr;
  logic [7:0] load_val, m_in;
  logic [7:0] q, m_cur;
  logic       max_tick, min_tick, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_m_updown_counter #(.N(8), .M_DEFAULT(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .oneshot(oneshot),
    .load(load), .load_val(load_val), .m_wr(m_wr), .m_in(m_in),
    .q(q), .m_cur(m_cur), .max_tick(max_tick), .min_tick(min_tick), .done(done)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; en = 1'b0; up = 1'b1; oneshot = 1'b0;
    load = 1'b0; m_wr = 1'b0; load_val = '0; m_in = '0;
    do_reset();
    #1;
    check("rst_q", q, 0);
    check("rst_m", m_cur, 10);
    check("rst_done", done, 0);

    // Up count with default modulus: 0..9,0..9,0..4.
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 25; i++) begin
      #1;
      check("up_q", q, i % 10);
      check("up_max", max_tick, (i % 10 == 9) ? 1 : 0);
      check("up_min", min_tick, 0);
      step();
    end

    // Down count from 0: 0,9,8,...
    do_reset();
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("dn_q", q, (10 - (i % 10)) % 10);
      check("dn_min", min_tick, (i % 10 == 0) ? 1 : 0);
      check("dn_max", max_tick, 0);
      step();
    end

    // Modulus write at q=3 applies only at the next up-wrap.
    do_reset();
    en = 1'b1; up = 1'b1;
    step(); step(); step();
    check("mw_q3", q, 3);
    m_wr = 1'b1; m_in = 8'd5;
    step();
    m_wr = 1'b0;
    for (int i = 4; i < 10; i++) begin
      #1;
      check("mw_q", q, i);
      check("mw_mold", m_cur, 10);
      check("mw_max", max_tick, (i == 9) ? 1 : 0);
      step();
    end
    check("mw_mnew", m_cur, 5);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("m5_q", q, i % 5);
      check("m5_max", max_tick, (i % 5 == 4) ? 1 : 0);
      step();
    end
    m_wr = 1'b1; m_in = 8'd1;
    step();
    m_wr = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("mw_small_ign", m_cur, 5);

    // Reset with a pending modulus clears everything.
    n = 0;
    while (q != 8'd1 && n < 20) begin step(); n++; end
    check("wait_q1", q, 1);
    m_wr = 1'b1; m_in = 8'd7;
    step();
    m_wr = 1'b0;
    step();
    check("pre_rst_q", q, 3);
    check("pre_rst_m", m_cur, 5);
    rst = 1'b1; load = 1'b1; load_val = 8'd4;
    step();
    rst = 1'b0; load = 1'b0;
    check("rst2_q", q, 0);
    check("rst2_m", m_cur, 10);
    check("rst2_done", done, 0);
    for (int i = 0; i < 10; i++) step();
    check("rst2_pend_clr_q", q, 0);
    check("rst2_pend_clr_m", m_cur, 10);

    // One-shot from load 7: 7,8,9 then hold with done.
    do_reset();
    oneshot = 1'b1; up = 1'b1; en = 1'b0;
    load = 1'b1; load_val = 8'd7;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 7; i < 10; i++) begin
      #1;
      check("os_q", q, i);
      check("os_max", max_tick, (i == 9) ? 1 : 0);
      check("os_done0", done, 0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      check("os_hold_q", q, 9);
      check("os_hold_done", done, 1);
      check("os_hold_max", max_tick, 0);
      step();
    end
    load = 1'b1; load_val = 8'd0;
    step();
    load = 1'b0;
    check("os_clr_done", done, 0);
    check("os_clr_q", q, 0);

    // Load clamp, then simultaneous load and modulus write.
    do_reset();
    oneshot = 1'b0; en = 1'b0;
    load = 1'b1; load_val = 8'd200;
    step();
    check("clamp_q", q, 9);
    en = 1'b1; up = 1'b1;
    load_val = 8'd6; m_wr = 1'b1; m_in = 8'd4;
    #1;
    check("load_blocks_tick", max_tick, 0);
    step();
    load = 1'b0; m_wr = 1'b0;
    check("lw_q", q, 6);
    check("lw_m", m_cur, 10);
    for (int i = 6; i < 10; i++) begin
      #1;
      check("lw_cnt_q", q, i);
      check("lw_cnt_m", m_cur, 10);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      #1;
      check("m4_q", q, i % 4);
      check("m4_m", m_cur, 4);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
